// File: rtl/cordic_gain_comp_if.sv
// rtl/cordic_gain_comp_if.sv - sample-in / result-out handshake bundle for cordic_gain_comp
interface cordic_gain_comp_if #(
    parameter int N = 32
);
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] in_x;
    logic signed [N-1:0] in_y;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] out_x;
    logic signed [N-1:0] out_y;
    logic                busy;

    // Block side: consumes samples, produces corrected results
    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_x, out_y, busy
    );

    // Environment side: CORDIC stage upstream plus result consumer downstream
    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_x, out_y, busy
    );
endinterface

// File: rtl/cordic_gain_comp.sv
// rtl/cordic_gain_comp.sv - CORDIC gain removal by serial shift-add multiply with K_COEF (optional CORDIC_GAIN_ROUND_EN)
module cordic_gain_comp #(
    parameter int             N      = 32,
    parameter int             FRAC   = 29,
    parameter logic [N-1:0]   K_COEF = 326016437
) (
    input  logic              clk,
    input  logic              rst_n,
    cordic_gain_comp_if.slave bus
);

    // Product of an N-bit signed sample and an N-bit unsigned coefficient,
    // plus a guard bit so the rounding offset can never wrap.
    localparam int AW = 2 * N + 1;
    localparam int CW = $clog2(N);

    localparam logic signed [AW-1:0] SAT_HI = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};
`ifdef CORDIC_GAIN_ROUND_EN
    localparam logic signed [AW-1:0] RND_HALF = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic                 accept;
    logic                 last;
    logic [CW-1:0]        cnt;
    logic signed [AW-1:0] lat_x;
    logic signed [AW-1:0] lat_y;
    logic signed [AW-1:0] acc_x;
    logic signed [AW-1:0] acc_y;
    logic signed [AW-1:0] add_x;
    logic signed [AW-1:0] add_y;
    logic signed [AW-1:0] sum_x;
    logic signed [AW-1:0] sum_y;
    logic signed [N-1:0]  out_x_q;
    logic signed [N-1:0]  out_y_q;

    // Drop the fractional bits of the Q-format product and clamp into N bits.
    function automatic logic signed [N-1:0] scale_sat(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] shifted;
`ifdef CORDIC_GAIN_ROUND_EN
        shifted = (acc + RND_HALF) >>> FRAC;
`else
        shifted = acc >>> FRAC;
`endif
        if (shifted > SAT_HI) begin
            return {1'b0, {(N-1){1'b1}}};
        end else if (shifted < SAT_LO) begin
            return {1'b1, {(N-1){1'b0}}};
        end else begin
            return shifted[N-1:0];
        end
    endfunction

    // in_ready depends only on state and out_ready so upstream valid cannot loop back
    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign last          = (state == BUSY) && (cnt == CW'(N - 1));
    assign bus.busy      = (state == BUSY);
    assign bus.out_valid = (state == DONE);
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: DONE chains straight into BUSY when a new sample is waiting
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) state_nx = BUSY;
            end
            BUSY: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_nx = accept ? BUSY : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Partial product for the current coefficient bit, both lanes in parallel
    always_comb begin
        add_x = '0;
        add_y = '0;
        if (K_COEF[cnt]) begin
            add_x = lat_x <<< cnt;
            add_y = lat_y <<< cnt;
        end
        sum_x = acc_x + add_x;
        sum_y = acc_y + add_y;
    end

    // Datapath: latch on accept, accumulate one bit per cycle, publish on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_x   <= '0;
            lat_y   <= '0;
            acc_x   <= '0;
            acc_y   <= '0;
            cnt     <= '0;
            out_x_q <= '0;
            out_y_q <= '0;
        end else if (accept) begin
            lat_x <= {{(N+1){bus.in_x[N-1]}}, bus.in_x};
            lat_y <= {{(N+1){bus.in_y[N-1]}}, bus.in_y};
            acc_x <= '0;
            acc_y <= '0;
            cnt   <= '0;
        end else if (state == BUSY) begin
            acc_x <= sum_x;
            acc_y <= sum_y;
            cnt   <= cnt + 1'b1;
            if (last) begin
                out_x_q <= scale_sat(sum_x);
                out_y_q <= scale_sat(sum_y);
            end
        end
    end

endmodule

// File: tb/tb_cordic_gain_comp.sv
// tb/tb_cordic_gain_comp.sv - scoreboard bench for cordic_gain_comp, default and CORDIC_GAIN_ROUND_EN builds
`timescale 1ns/1ps
module tb_cordic_gain_comp;

    localparam int          N    = 32;
    localparam int          FRAC = 29;
    localparam logic [31:0] K    = 32'd326016437;
    localparam logic [31:0] K2   = 32'h4000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        int          acc_cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    cordic_gain_comp_if #(.N(N)) bus ();
    cordic_gain_comp_if #(.N(N)) sbus ();

    cordic_gain_comp #(.N(N), .FRAC(FRAC), .K_COEF(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    cordic_gain_comp #(.N(N), .FRAC(FRAC), .K_COEF(K2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus.slave)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Golden product via full-width multiply, independent of shift-add ordering
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] k);
        longint p;
        p = longint'($signed(x)) * longint'({32'b0, k});
`ifdef CORDIC_GAIN_ROUND_EN
        p = p + 64'sd268435456;
`endif
        p = p >>> FRAC;
        if (p > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (p < -64'sd2147483648) return 32'h8000_0000;
        return p[31:0];
    endfunction

    // Present a sample, wait for acceptance, push the expectation with its accept cycle
    task automatic send(input int which, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ex, input logic [31:0] ey, output int acc_cyc);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        acc_cyc = -1;
        if (which == 0) begin
            bus.in_x = x; bus.in_y = y; bus.in_valid = 1'b1;
        end else begin
            sbus.in_x = x; sbus.in_y = y; sbus.in_valid = 1'b1;
        end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if ((which == 0) ? bus.in_ready : sbus.in_ready) ok = 1'b1;
        end
        check("accept", 32'(ok), 32'd1);
        if (ok) begin
            acc_cyc = cyc + 1;
            e.x = ex; e.y = ey; e.acc_cyc = acc_cyc;
            if (which == 0) q0.push_back(e);
            else q1.push_back(e);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        sbus.in_valid = 1'b0;
    endtask

    task automatic drain(input int which);
        for (int i = 0; i < 200 && ((which == 0) ? q0.size() : q1.size()) > 0; i++) @(negedge clk);
        check("drain", 32'((which == 0) ? q0.size() : q1.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic pv0 = 1'b0;
    logic pv1 = 1'b0;

    // Monitor for the default-coefficient instance: latency on valid rise, data on handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.out_valid && !pv0) begin
                if (q0.size() == 0) check("spurious_valid", 32'd1, 32'd0);
                else check("latency", 32'(cyc - q0[0].acc_cyc), 32'(N));
            end
            if (bus.out_valid && bus.out_ready && q0.size() > 0) begin
                e = q0.pop_front();
                check("out_x", bus.out_x, e.x);
                check("out_y", bus.out_y, e.y);
            end
        end
        pv0 = rst_n ? bus.out_valid : 1'b0;
    end

    // Monitor for the saturation instance
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sbus.out_valid && !pv1) begin
                if (q1.size() == 0) check("sat_spurious_valid", 32'd1, 32'd0);
                else check("sat_latency", 32'(cyc - q1[0].acc_cyc), 32'(N));
            end
            if (sbus.out_valid && sbus.out_ready && q1.size() > 0) begin
                e = q1.pop_front();
                check("sat_out_x", sbus.out_x, e.x);
                check("sat_out_y", sbus.out_y, e.y);
            end
        end
        pv1 = rst_n ? sbus.out_valid : 1'b0;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        int a;
        int a_prev;
        int c0;
        logic [31:0] sx[4];
        logic [31:0] sy[4];
        logic [31:0] small_y;
        logic [31:0] bp_x, bp_y, b2_y;

`ifdef CORDIC_GAIN_ROUND_EN
        small_y = 32'd1;
        bp_x    = 32'd163008219;
        bp_y    = -32'sd163008218;
        b2_y    = 32'd489024656;
`else
        small_y = 32'd0;
        bp_x    = 32'd163008218;
        bp_y    = -32'sd163008219;
        b2_y    = 32'd489024655;
`endif
        sx = '{32'h1234_5678, 32'h7FFF_FFFF, 32'h0000_0001, 32'h1999_999A};
        sy = '{32'hEDCB_A988, 32'h8000_0000, 32'hFFFF_FFFE, 32'hC000_0000};

        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.out_ready = 1'b1;
        sbus.in_valid = 1'b0; sbus.in_x = '0; sbus.in_y = '0; sbus.out_ready = 1'b1;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_x", bus.out_x, 32'd0);
        check("rst_out_y", bus.out_y, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Unity inputs
        send(0, 32'h2000_0000, 32'hE000_0000, 32'd326016437, -32'sd326016437, a);
        check("busy_high", 32'(bus.busy), 32'd1);
        check("busy_in_ready", 32'(bus.in_ready), 32'd0);
        drain(0);

        // Zero and smallest magnitudes
        send(0, 32'h0, 32'h1, 32'h0, small_y, a);
        drain(0);
        send(0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, a);
        drain(0);

        // Saturation with a 2.0 coefficient
        send(1, 32'h6000_0000, 32'hA000_0000, 32'h7FFF_FFFF, 32'h8000_0000, a);
        drain(1);

        // Backpressure then same-cycle accept of a new sample
        bus.out_ready = 1'b0;
        send(0, 32'h1000_0000, 32'hF000_0000, bp_x, bp_y, a);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (bus.out_valid) seen = 1'b1;
            end
            check("bp_valid_seen", 32'(seen), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_x", bus.out_x, bp_x);
            check("bp_hold_y", bus.out_y, bp_y);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        c0 = cyc;
        bus.out_ready = 1'b1;
        send(0, 32'h0800_0000, 32'h3000_0000, 32'd81504109, b2_y, a);
        check("bp_same_cycle_accept", 32'(a), 32'(c0 + 1));
        drain(0);

        // Streaming with valid held
        a_prev = 0;
        for (int i = 0; i < 4; i++) begin
            send(0, sx[i], sy[i], model(sx[i], K), model(sy[i], K), a);
            if (i > 0) check("stream_interval", 32'(a - a_prev), 32'(N + 1));
            a_prev = a;
        end
        drain(0);

        // Reset while BUSY at cnt=10
        send(0, 32'h2000_0000, 32'h1000_0000, 32'd326016437, bp_x, a);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q0.delete();
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_x", bus.out_x, 32'd0);
        check("midrst_out_y", bus.out_y, 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        send(0, 32'h2000_0000, 32'h2000_0000, 32'd326016437, 32'd326016437, a);
        drain(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_gain_comp.md
Name: cordic_gain_comp

Overview:
- Downstream consumer of the CORDIC rotation pipeline. It removes the CORDIC gain (about 1.6468) by multiplying the pipeline's X and Y outputs by the constant K_COEF (about 0.60725).
- Uses a sequential shift-add multiplier, one coefficient bit per clock, with X and Y processed in parallel.
- Takes valid-qualified samples from the CORDIC output stage and presents corrected sin/cos (or rotated Xr/Yr) with a valid/ready handshake.
- All data is Q3.29 signed fixed point, matching the CORDIC datapath.

Parameters:
- N, 32, data width in bits; Q(N-FRAC).FRAC signed format.
- FRAC, 29, number of fractional bits.
- K_COEF, 326016437, unsigned gain-compensation coefficient in Q3.29 (0.607252935); must be below 2^N.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_x/in_y carry a valid sample.
- in_ready  out  1  block can accept a sample this cycle.
- in_x  in  N  signed X (cos / Xr) from the CORDIC stage.
- in_y  in  N  signed Y (sin / Yr) from the CORDIC stage.
- out_valid  out  1  out_x/out_y hold a corrected result.
- out_ready  in  1  downstream accepts the result.
- out_x  out  N  signed in_x*K_COEF, Q3.29.
- out_y  out  N  signed in_y*K_COEF, Q3.29.
- busy  out  1  high while in state BUSY.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, bit counter=0, accumulators=0.
  - out_valid=0, out_x=0, out_y=0, busy=0.
  - in_ready goes to 1 as soon as reset is released.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_x/in_y (sign-extended to 2N+1 bits), clear both accumulators, set cnt=0, go to BUSY.
  - BUSY: in_ready=0, busy=1. Each edge, if K_COEF[cnt]=1, add (latched_x<<cnt) to acc_x and (latched_y<<cnt) to acc_y. Then cnt++. On the edge where cnt==N-1, register the results and go to DONE with out_valid=1.
  - DONE: out_valid=1, with out_x/out_y held stable. If out_ready=1, the result is consumed:
    - with in_valid=1 in the same cycle, accept the new sample and go directly to BUSY;
    - otherwise go to IDLE.
  - DONE with out_ready=0: hold all outputs.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational from state and out_ready only; no path from in_valid.
- Timing: out_valid rises exactly N clock edges after the accepting edge. Back-to-back throughput is one sample per N+1 cycles.
- Arithmetic:
  - Accumulators are 2N+1 bits signed.
  - Result = acc >>> FRAC (arithmetic shift, i.e. truncation toward minus infinity).
  - Saturate to N bits: results above 2^(N-1)-1 become 0x7FFF_FFFF; results below -2^(N-1) become 0x8000_0000.
  - With the default K_COEF saturation cannot occur; it is required for overridden coefficients.
- X and Y are independent lanes with identical timing.
- out_x/out_y update only on the BUSY->DONE edge and are otherwise held, including in IDLE.
- in_x/in_y are sampled only at the accepting edge; changes while BUSY are ignored.
- Reset mid-operation (BUSY or DONE) aborts immediately to the reset values. No partial result is ever presented.
- in_valid=1 while BUSY: not accepted, and no data is lost. The upstream holds the sample until in_ready.

Optional Feature:
- Macro CORDIC_GAIN_ROUND_EN.
- Defined: add 2^(FRAC-1) to each accumulator before the >>>FRAC shift (round half up), then saturate.
- Undefined: plain arithmetic-shift truncation.
- Latency and handshake are identical in both builds.

Test Plan:
- Unity inputs: in_x=0x2000_0000 (1.0), in_y=0xE000_0000 (-1.0), both accepted at edge t.
  - out_valid rises at edge t+N (N=32).
  - out_x=326016437 and out_y=-326016437.
- Zero and smallest inputs: in_x=0, in_y=1.
  - Truncating build: out_x=0, out_y=0.
  - CORDIC_GAIN_ROUND_EN build: out_y=1.
  - in_y=-1 gives out_y=-1 in both builds.
- Saturation with K_COEF=0x4000_0000 (2.0):
  - in_x=0x6000_0000 (3.0) gives out_x=0x7FFF_FFFF.
  - in_y=0xA000_0000 (-3.0) gives out_y=0x8000_0000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_valid, out_x and out_y stay stable and in_ready=0.
  - Raise out_ready with in_valid=1 and a new sample: that sample is accepted the same cycle and the next out_valid follows N edges later.
- Streaming: 4 samples with in_valid held high and out_ready=1.
  - Samples are accepted every N+1 cycles.
  - Outputs appear in order, each matching a golden x*K>>>29 model; none are dropped or duplicated.
- Reset mid-BUSY: assert rst_n=0 at cnt=10.
  - Outputs and out_valid go to 0 immediately.
  - After release, in_ready=1 and a fresh 1.0 sample yields 326016437.
